// File: rtl/lidar_rx_pkg.sv
// Shared types, defaults and the CRC-8 helper for the LiDAR receive sequencer.
// The CRC helper is only referenced when LIDAR_RX_CRC_EN is defined.
package lidar_rx_pkg;

    localparam int unsigned PKT_LEN_DEFAULT     = 47;
    localparam logic [7:0]  HDR_BYTE_DEFAULT    = 8'h54;
    localparam logic [7:0]  VERLEN_BYTE_DEFAULT = 8'h2C;
    localparam logic [7:0]  CRC8_POLY           = 8'h4D;

    typedef logic [1:0] bit_state_t;
    localparam bit_state_t BIT_IDLE  = 2'd0;
    localparam bit_state_t BIT_START = 2'd1;
    localparam bit_state_t BIT_DATA  = 2'd2;
    localparam bit_state_t BIT_STOP  = 2'd3;

    typedef logic [1:0] pkt_state_t;
    localparam pkt_state_t PKT_HUNT = 2'd0;
    localparam pkt_state_t PKT_VER  = 2'd1;
    localparam pkt_state_t PKT_BODY = 2'd2;

    // MSB-first, non-reflected, no final XOR.
    function automatic logic [7:0] crc8_update(input logic [7:0] crc, input logic [7:0] data);
        logic [7:0] c;
        c = crc ^ data;
        for (int i = 0; i < 8; i++) begin
            c = c[7] ? ((c << 1) ^ CRC8_POLY) : (c << 1);
        end
        return c;
    endfunction

endpackage

// File: rtl/lidar_rx_sequencer_uart_rx_os.sv
// Oversampling UART receiver: 2-FF synchronizer, start/data/stop bit FSM and
// mid-bit 3-tick majority sampler. Emits a combinational byte strobe / frame error.
module uart_rx_os
    import lidar_rx_pkg::*;
#(
    parameter int OVERSAMPLE = 25
) (
    input  logic       clk_in,
    input  logic       reset_n,
    input  logic       rx,
    input  logic       enable,
    output logic [7:0] rx_data,
    output logic       rx_stb,
    output logic       rx_ferr
);

    localparam int             TW        = $clog2(OVERSAMPLE);
    localparam logic [TW-1:0]  TICK_LAST = TW'(OVERSAMPLE - 1);
    // Samples land on ticks mid-1, mid, mid+1; the decision is taken on the last.
    localparam logic [TW-1:0]  TICK_DEC  = TW'(OVERSAMPLE / 2 + 1);

    logic          rx_meta_q, rx_meta_d;
    logic          rx_sync_q, rx_sync_d;
    logic          rx_prev_q, rx_prev_d;
    logic [1:0]    hist_q, hist_d;
    logic [1:0]    settle_q, settle_d;
    bit_state_t    state_q, state_d;
    logic [TW-1:0] tick_q, tick_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic [7:0]    shift_q, shift_d;

    logic settled;
    logic majority;
    logic at_dec;
    logic at_end;

    assign settled  = (settle_q == 2'd3);
    assign majority = (hist_q[1] & hist_q[0]) | (hist_q[1] & rx_sync_q) | (hist_q[0] & rx_sync_q);
    assign at_dec   = (tick_q == TICK_DEC);
    assign at_end   = (tick_q == TICK_LAST);
    assign rx_data  = shift_q;

    always_comb begin
        // NOTE: every signal written here gets a default first, so no latch can be inferred.
        rx_meta_d = rx;
        rx_sync_d = rx_meta_q;
        rx_prev_d = rx_sync_q;
        hist_d    = {hist_q[0], rx_sync_q};
        settle_d  = settled ? settle_q : settle_q + 2'd1;
        state_d   = state_q;
        tick_d    = at_end ? '0 : tick_q + 1'b1;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        rx_stb    = 1'b0;
        rx_ferr   = 1'b0;

        case (state_q)
            BIT_IDLE: begin
                tick_d = '0;
                // Edge qualification waits until the synchronizer holds real line values,
                // so a line already low at reset release never looks like a start.
                if (enable && settled && rx_prev_q && !rx_sync_q) begin
                    state_d = BIT_START;
                end
            end
            BIT_START: begin
                if (at_dec && majority) begin
                    state_d = BIT_IDLE;
                end else if (at_end) begin
                    state_d   = BIT_DATA;
                    bit_cnt_d = 3'd0;
                end
            end
            BIT_DATA: begin
                if (at_dec) begin
                    shift_d = {majority, shift_q[7:1]};
                end
                if (at_end) begin
                    if (bit_cnt_q == 3'd7) begin
                        state_d = BIT_STOP;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                    end
                end
            end
            BIT_STOP: begin
                if (at_dec) begin
                    state_d = BIT_IDLE;
                    rx_stb  = majority;
                    rx_ferr = !majority;
                end
            end
            default: state_d = BIT_IDLE;
        endcase

        if (!enable) begin
            state_d = BIT_IDLE;
            rx_stb  = 1'b0;
            rx_ferr = 1'b0;
        end
    end

    // NOTE: sequential state is only ever assigned with non-blocking (<=) assignments.
    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
            rx_prev_q <= 1'b1;
            hist_q    <= 2'b11;
            settle_q  <= 2'd0;
            state_q   <= BIT_IDLE;
            tick_q    <= '0;
            bit_cnt_q <= 3'd0;
            shift_q   <= 8'h00;
        end else begin
            rx_meta_q <= rx_meta_d;
            rx_sync_q <= rx_sync_d;
            rx_prev_q <= rx_prev_d;
            hist_q    <= hist_d;
            settle_q  <= settle_d;
            state_q   <= state_d;
            tick_q    <= tick_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
        end
    end

endmodule

// File: rtl/lidar_rx_sequencer.sv
// LiDAR receive sequencer: packet lock (0x54, 0x2C), payload streaming and CRC status.
// Define LIDAR_RX_CRC_EN to compile in the CRC-8 check; otherwise pkt_ok is 1 on every pkt_done.
module lidar_rx_sequencer
    import lidar_rx_pkg::*;
#(
    parameter int         OVERSAMPLE  = 25,
    parameter int         PKT_LEN     = PKT_LEN_DEFAULT,
    parameter logic [7:0] HDR_BYTE    = HDR_BYTE_DEFAULT,
    parameter logic [7:0] VERLEN_BYTE = VERLEN_BYTE_DEFAULT
) (
    input  logic       clk_in,
    input  logic       reset_n,
    input  logic       rx,
    input  logic       enable,
    output logic [7:0] byte_out,
    output logic       byte_valid,
    output logic [5:0] byte_idx,
    output logic       pkt_done,
    output logic       pkt_ok,
    output logic       frame_err,
    output logic       locked
);

    localparam logic [5:0] LAST_IDX = 6'(PKT_LEN - 1);

    logic [7:0] rx_data;
    logic       rx_stb;
    logic       rx_ferr;
    logic       crc_ok;

    pkt_state_t pkt_state_q, pkt_state_d;
    logic [5:0] idx_q, idx_d;
    logic [7:0] byte_out_q, byte_out_d;
    logic [5:0] byte_idx_q, byte_idx_d;
    logic       byte_valid_q, byte_valid_d;
    logic       pkt_done_q, pkt_done_d;
    logic       pkt_ok_q, pkt_ok_d;
    logic       frame_err_q, frame_err_d;

    uart_rx_os #(
        .OVERSAMPLE(OVERSAMPLE)
    ) u_uart (
        .clk_in (clk_in),
        .reset_n(reset_n),
        .rx     (rx),
        .enable (enable),
        .rx_data(rx_data),
        .rx_stb (rx_stb),
        .rx_ferr(rx_ferr)
    );

`ifdef LIDAR_RX_CRC_EN
    logic [7:0] crc_q, crc_d;

    always_comb begin
        crc_d = crc_q;
        if (rx_stb) begin
            if (pkt_state_q == PKT_BODY) begin
                if (idx_q != LAST_IDX) begin
                    crc_d = crc8_update(crc_q, rx_data);
                end
            end else if (rx_data == HDR_BYTE) begin
                crc_d = crc8_update(8'h00, rx_data);
            end else if (pkt_state_q == PKT_VER && rx_data == VERLEN_BYTE) begin
                crc_d = crc8_update(crc_q, rx_data);
            end
        end
    end

    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            crc_q <= 8'h00;
        end else begin
            crc_q <= crc_d;
        end
    end

    assign crc_ok = (crc_q == rx_data);
`else
    assign crc_ok = 1'b1;
`endif

    always_comb begin
        pkt_state_d  = pkt_state_q;
        idx_d        = idx_q;
        byte_out_d   = byte_out_q;
        byte_idx_d   = byte_idx_q;
        byte_valid_d = 1'b0;
        pkt_done_d   = 1'b0;
        pkt_ok_d     = 1'b0;
        frame_err_d  = rx_ferr;

        if (rx_ferr) begin
            pkt_state_d = PKT_HUNT;
        end else if (rx_stb) begin
            case (pkt_state_q)
                PKT_HUNT: begin
                    if (rx_data == HDR_BYTE) begin
                        pkt_state_d = PKT_VER;
                    end
                end
                PKT_VER: begin
                    if (rx_data == VERLEN_BYTE) begin
                        pkt_state_d = PKT_BODY;
                        idx_d       = 6'd2;
                    end else if (rx_data != HDR_BYTE) begin
                        pkt_state_d = PKT_HUNT;
                    end
                end
                PKT_BODY: begin
                    if (idx_q == LAST_IDX) begin
                        pkt_done_d  = 1'b1;
                        pkt_ok_d    = crc_ok;
                        pkt_state_d = PKT_HUNT;
                    end else begin
                        byte_valid_d = 1'b1;
                        byte_out_d   = rx_data;
                        byte_idx_d   = idx_q;
                        idx_d        = idx_q + 6'd1;
                    end
                end
                default: pkt_state_d = PKT_HUNT;
            endcase
        end

        if (!enable) begin
            pkt_state_d = PKT_HUNT;
        end
    end

    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            pkt_state_q  <= PKT_HUNT;
            idx_q        <= 6'd0;
            byte_out_q   <= 8'h00;
            byte_idx_q   <= 6'd0;
            byte_valid_q <= 1'b0;
            pkt_done_q   <= 1'b0;
            pkt_ok_q     <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            pkt_state_q  <= pkt_state_d;
            idx_q        <= idx_d;
            byte_out_q   <= byte_out_d;
            byte_idx_q   <= byte_idx_d;
            byte_valid_q <= byte_valid_d;
            pkt_done_q   <= pkt_done_d;
            pkt_ok_q     <= pkt_ok_d;
            frame_err_q  <= frame_err_d;
        end
    end

    assign byte_out   = byte_out_q;
    assign byte_valid = byte_valid_q;
    assign byte_idx   = byte_idx_q;
    assign pkt_done   = pkt_done_q;
    assign pkt_ok     = pkt_ok_q;
    assign frame_err  = frame_err_q;
    assign locked     = (pkt_state_q == PKT_BODY);

endmodule

// File: tb/tb_lidar_rx_sequencer.sv
// Randomized bench for lidar_rx_sequencer: serial packets driven on rx, every strobe
// compared against an expectation queue built from the packet rules.
module tb_lidar_rx_sequencer;

    localparam int HALF      = 50;
    localparam int BIT_NOM   = 2500;
    localparam int BIT_FAST  = 2425;
    localparam int BIT_SLOW  = 2575;
    localparam int BYTE_GAP  = 625;

    logic       clk_in = 1'b0;
    logic       reset_n = 1'b0;
    logic       rx = 1'b1;
    logic       enable = 1'b0;
    logic [7:0] byte_out;
    logic       byte_valid;
    logic [5:0] byte_idx;
    logic       pkt_done;
    logic       pkt_ok;
    logic       frame_err;
    logic       locked;

    lidar_rx_sequencer dut (
        .clk_in    (clk_in),
        .reset_n   (reset_n),
        .rx        (rx),
        .enable    (enable),
        .byte_out  (byte_out),
        .byte_valid(byte_valid),
        .byte_idx  (byte_idx),
        .pkt_done  (pkt_done),
        .pkt_ok    (pkt_ok),
        .frame_err (frame_err),
        .locked    (locked)
    );

    always #HALF clk_in = ~clk_in;

    // kind: 0 payload byte, 1 packet done, 2 frame error
    typedef struct {
        int kind;
        int data;
        int idx;
        int ok;
    } ev_t;

    ev_t        exp_q[$];
    int         n_checks = 0;
    int         n_fail = 0;
    logic [7:0] pkt[47];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", tag, got, want, $time);
        end
    endtask

    // Long division of the message bitstream by x^8+x^6+x^3+x^2+1.
    function automatic logic [7:0] model_crc(input int n);
        logic [7:0] r;
        logic       fb;
        r = 8'h00;
        for (int i = 0; i < n; i++) begin
            for (int b = 7; b >= 0; b--) begin
                fb = r[7] ^ pkt[i][b];
                r  = {r[6:0], 1'b0} ^ (fb ? 8'h4D : 8'h00);
            end
        end
        return r;
    endfunction

    function automatic int expected_ok();
`ifdef LIDAR_RX_CRC_EN
        return (model_crc(46) == pkt[46]) ? 1 : 0;
`else
        return 1;
`endif
    endfunction

    task automatic make_packet();
        pkt[0] = 8'h54;
        pkt[1] = 8'h2C;
        for (int i = 2; i < 46; i++) pkt[i] = 8'($urandom_range(0, 255));
        pkt[46] = model_crc(46);
    endtask

    task automatic expect_body(input int last);
        for (int i = 2; i <= last; i++) exp_q.push_back('{0, int'(pkt[i]), i, 0});
    endtask

    task automatic expect_done();
        exp_q.push_back('{1, 0, 46, expected_ok()});
    endtask

    task automatic send_byte(input logic [7:0] b, input int bt, input bit stop_ok);
        rx = 1'b0;
        #bt;
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            #bt;
        end
        rx = stop_ok;
        #bt;
        rx = 1'b1;
        if (stop_ok) #BYTE_GAP;
        else #(2 * bt);
    endtask

    task automatic send_range(input int from, input int to, input int bt);
        for (int i = from; i <= to; i++) send_byte(pkt[i], bt, 1'b1);
    endtask

    always @(negedge clk_in) begin
        if (reset_n && (byte_valid || pkt_done || frame_err)) begin
            ev_t e;
            int  kind;
            kind = byte_valid ? 0 : (pkt_done ? 1 : 2);
            check("one_strobe", 32'(byte_valid) + 32'(pkt_done) + 32'(frame_err), 32'd1);
            if (exp_q.size() == 0) begin
                check("spurious_strobe_kind", 32'(kind), 32'hFF);
            end else begin
                e = exp_q.pop_front();
                check("strobe_kind", 32'(kind), 32'(e.kind));
                if (kind == 0) begin
                    check("byte_idx", 32'(byte_idx), 32'(e.idx));
                    check("byte_out", 32'(byte_out), 32'(e.data));
                    check("pkt_ok_idle", 32'(pkt_ok), 32'd0);
                end else if (kind == 1) begin
                    check("pkt_ok", 32'(pkt_ok), 32'(e.ok));
                end
            end
        end
    end

    task automatic check_all_zero(input string tag);
        check({tag, "_byte_valid"}, 32'(byte_valid), 32'd0);
        check({tag, "_pkt_done"}, 32'(pkt_done), 32'd0);
        check({tag, "_pkt_ok"}, 32'(pkt_ok), 32'd0);
        check({tag, "_frame_err"}, 32'(frame_err), 32'd0);
        check({tag, "_byte_out"}, 32'(byte_out), 32'd0);
        check({tag, "_byte_idx"}, 32'(byte_idx), 32'd0);
        check({tag, "_locked"}, 32'(locked), 32'd0);
    endtask

    initial begin
        #320;
        check_all_zero("reset");
        reset_n = 1'b1;
        enable  = 1'b1;
        #(10 * BIT_NOM);

        // Lone byte outside a packet.
        send_byte(8'hA5, BIT_NOM, 1'b1);
        #BIT_NOM;
        check("single_locked", 32'(locked), 32'd0);
        check("single_no_events", 32'(exp_q.size()), 32'd0);

        // Clean packet at nominal baud.
        make_packet();
        expect_body(45);
        expect_done();
        send_range(0, 45, BIT_NOM);
        check("good_locked_body", 32'(locked), 32'd1);
        send_range(46, 46, BIT_NOM);
        #BIT_NOM;
        check("good_locked_end", 32'(locked), 32'd0);
        check("good_drained", 32'(exp_q.size()), 32'd0);

        // Short glitch on an idle line, then a packet with byte 20 corrupted at +3% baud.
        rx = 1'b0;
        #300;
        rx = 1'b1;
        #BIT_NOM;
        make_packet();
        pkt[20] = pkt[20] ^ 8'($urandom_range(1, 255));
        expect_body(45);
        expect_done();
        send_range(0, 46, BIT_FAST);
        #BIT_NOM;
        check("corrupt_drained", 32'(exp_q.size()), 32'd0);
        check("corrupt_locked_end", 32'(locked), 32'd0);

        // Stop bit low on byte 10, rest of the packet must be ignored.
        make_packet();
        for (int i = 11; i < 47; i++) if (pkt[i] == 8'h54) pkt[i] = 8'h55;
        expect_body(9);
        exp_q.push_back('{2, 0, 0, 0});
        send_range(0, 9, BIT_NOM);
        send_byte(pkt[10], BIT_NOM, 1'b0);
        check("ferr_locked", 32'(locked), 32'd0);
        send_range(11, 46, BIT_NOM);
        #BIT_NOM;
        check("ferr_drained", 32'(exp_q.size()), 32'd0);

        // Recovery packet at -3% baud.
        make_packet();
        expect_body(45);
        expect_done();
        send_range(0, 46, BIT_SLOW);
        #BIT_NOM;
        check("slow_drained", 32'(exp_q.size()), 32'd0);

        // Reset mid-packet while receiving byte 30.
        make_packet();
        expect_body(29);
        send_range(0, 29, BIT_NOM);
        check("pre_rst_locked", 32'(locked), 32'd1);
        check("pre_rst_byte_idx", 32'(byte_idx), 32'd29);
        check("pre_rst_byte_out", 32'(byte_out), 32'(pkt[29]));
        rx = 1'b0;
        #(3 * BIT_NOM);
        reset_n = 1'b0;
        #1;
        check_all_zero("mid_rst");
        rx = 1'b1;
        #524;
        reset_n = 1'b1;
        #(3 * BIT_NOM);
        check("post_rst_drained", 32'(exp_q.size()), 32'd0);

        make_packet();
        expect_body(45);
        expect_done();
        send_range(0, 46, BIT_NOM);
        #BIT_NOM;
        check("final_drained", 32'(exp_q.size()), 32'd0);
        check("final_locked", 32'(locked), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/lidar_rx_sequencer.md
# lidar_rx_sequencer

Receive-side sequencer for the LiDAR serial link: it runs on the 5.76 MHz oversampling clock (25 × 230,400 baud) and recovers UART bytes from the LiDAR line using mid-bit majority sampling. It locks onto 47-byte LiDAR packets (header 0x54, ver/len 0x2C) and streams payload bytes to the downstream point-decoding logic. When the packet's CRC byte arrives, it reports packet completion and CRC status.

## Interface
Parameters:
- OVERSAMPLE, 25: clock ticks per bit.
- PKT_LEN, 47: bytes per packet, header and CRC included.
- HDR_BYTE, 8'h54: packet header byte.
- VERLEN_BYTE, 8'h2C: ver/len byte.

Ports:
- clk_in, in, 1: 5.76 MHz oversampling clock from the clock source.
- reset_n, in, 1: asynchronous, active-low reset.
- rx, in, 1: LiDAR serial line, idle high, asynchronous to clk_in.
- enable, in, 1: run enable.
- byte_out, out, 8: payload byte.
- byte_valid, out, 1: one-cycle strobe qualifying byte_out and byte_idx.
- byte_idx, out, 6: packet index of byte_out, range 2..45.
- pkt_done, out, 1: one-cycle strobe when the CRC byte (index 46) is received.
- pkt_ok, out, 1: CRC match; valid only while pkt_done is high.
- frame_err, out, 1: one-cycle strobe when a stop bit is sampled low.
- locked, out, 1: high from ver/len acceptance until packet end or abort.

## Operation
- rx passes through a 2-FF synchronizer, reset value 1.
- Bit FSM states: IDLE, START, DATA, STOP.
  - IDLE → START on a synced rx 1→0 edge while enable=1; the tick counter clears.
  - Each bit's sample value is the majority of ticks 11, 12 and 13.
  - START: if the start-bit sample is 1 (glitch), return to IDLE. Otherwise go to DATA.
  - DATA: capture 8 bits LSB first, one bit per 25 ticks.
  - STOP: if the stop sample is 1, raise the internal byte strobe. If it is 0, pulse frame_err, drop the byte and force the packet FSM to HUNT. Either way return to IDLE after tick 13, so the next start edge is catchable.
- Packet FSM states: HUNT, VER, BODY.
  - HUNT → VER on HDR_BYTE.
  - VER → BODY on VERLEN_BYTE. On HDR_BYTE, stay in VER. On any other byte, go to HUNT.
  - BODY counts indices 2..46. Indices 2..45 produce byte_valid. Index 46 produces pkt_done, then the FSM returns to HUNT.
- CRC8: polynomial 0x4D, init 0x00, MSB-first, no reflection, no final XOR. It covers indices 0..45, is updated one byte per strobe, and reloads on header acceptance.
- enable=0: both FSMs go to IDLE/HUNT on the next edge; a partial byte or packet is discarded with no strobes.
- Reset values: all outputs 0, counters 0, CRC 0x00, FSMs in IDLE/HUNT.

## Timing
- byte_valid, pkt_done and frame_err are registered and assert exactly one cycle after the stop-bit decision tick.
- Latency from the rx stop-bit midpoint to a strobe is 2 sync cycles + 1 cycle.
- At most one strobe per byte time (250 cycles). No backpressure: the consumer must accept every strobe.
- pkt_ok changes only alongside pkt_done.
- reset_n low mid-packet clears everything immediately. After release, the bit FSM first waits for a fresh falling edge; a line that is already low is not treated as a start.

## Configuration
- LIDAR_RX_CRC_EN defined: CRC is computed as above and pkt_ok = (crc == byte 46).
- LIDAR_RX_CRC_EN undefined: no CRC logic is compiled in; pkt_ok is 1 whenever pkt_done is 1.

## Structure
- Shared package lidar_rx_pkg holds:
  - bit and packet state enums;
  - HDR_BYTE, VERLEN_BYTE and PKT_LEN defaults;
  - CRC polynomial constant 8'h4D;
  - crc8_update function.
- Sub-module uart_rx_os contains the synchronizer, the bit FSM and the majority sampler. It outputs an internal byte strobe plus data and frame_err. The top level holds the packet FSM and CRC.

## Test plan
- Single byte 0xA5 at exact 230,400 baud, outside a packet → no byte_valid, locked stays 0.
- Full valid 47-byte packet with correct CRC → 44 byte_valid strobes with byte_idx 2..45 in order, then pkt_done=1 with pkt_ok=1, then locked=0.
- Same packet with byte 20 corrupted → identical strobes, pkt_done=1, pkt_ok=0. With LIDAR_RX_CRC_EN undefined, pkt_ok=1.
- Stop bit forced low on byte 10 → frame_err pulse, no further byte_valid, back to HUNT. A following good packet decodes normally.
- Baud offset of ±3% and a 3-tick glitch on the rx line during idle → bytes decode correctly, and the glitch produces no start.
- reset_n pulsed low at byte 30 → all outputs 0 immediately. A subsequent clean packet decodes with pkt_ok=1.
